csi_read32_packer: RTL



---
 rtl/csi_read32_packer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/csi_read32_packer.sv
// CSI byte stream to 32-bit word packer with a word FIFO feeding the Xillybus read_32 stream.
// Optional build macro CSI_READ32_FRAME_EOF_EN: deliver exactly one frame per open, then signal EOF.
module csi_read32_packer #(
    parameter int DEPTH_LOG2 = 9
) (
    input  logic        bus_clk,
    input  logic        reset,
    input  logic        csi_valid,
    input  logic [7:0]  csi_data,
    input  logic        csi_last,
    input  logic        user_r_read_32_rden,
    input  logic        user_r_read_32_open,
    output logic [31:0] user_r_read_32_data,
    output logic        user_r_read_32_empty,
    output logic        user_r_read_32_eof,
    output logic        overflow,
    output logic [15:0] drop_count
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE    = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic [1:0]            byte_idx;
    logic [23:0]           partial;
    logic                  open_q;
    logic                  eof_pending;
    logic [31:0]           rd_data;

    logic                  byte_take;
    logic                  commit;
    logic                  full;
    logic                  wr_en;
    logic                  drop;
    logic                  rd_en;
    logic                  open_rise;
    logic [31:0]           word_next;

    // Bytes are only accepted while the device is open and no frame has ended yet.
    assign byte_take = csi_valid && user_r_read_32_open && !eof_pending;
    assign commit    = byte_take && ((byte_idx == 2'd3) || csi_last);
    assign full      = (count == FULL_COUNT);
    assign wr_en     = commit && !full;
    assign drop      = commit && full;
    assign rd_en     = user_r_read_32_rden && user_r_read_32_open && (count != '0);
    assign open_rise = user_r_read_32_open && !open_q;

    assign user_r_read_32_data  = rd_data;
    assign user_r_read_32_empty = (count == '0);

    always_comb begin
        word_next = {8'h00, partial};
        case (byte_idx)
            2'd0: word_next = {24'h000000, csi_data};
            2'd1: word_next = {16'h0000, csi_data, partial[7:0]};
            2'd2: word_next = {8'h00, csi_data, partial[15:0]};
            2'd3: word_next = {csi_data, partial};
            default: word_next = {8'h00, partial};
        endcase
    end

    always_ff @(posedge bus_clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= word_next;
        end
    end

    always_ff @(posedge bus_clk or posedge reset) begin
        if (reset) begin
            byte_idx   <= '0;
            partial    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            rd_data    <= '0;
            open_q     <= 1'b0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            open_q <= user_r_read_32_open;
            if (!user_r_read_32_open) begin
                // Closed: buffered data is flushed, drop status is held for inspection.
                byte_idx <= '0;
                partial  <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
            end else begin
                if (open_rise) begin
                    overflow   <= 1'b0;
                    drop_count <= '0;
                end else if (drop) begin
                    overflow <= 1'b1;
                    if (drop_count != 16'hFFFF) begin
                        drop_count <= drop_count + 16'd1;
                    end
                end

                if (byte_take) begin
                    if (commit) begin
                        byte_idx <= '0;
                        partial  <= '0;
                    end else begin
                        byte_idx <= byte_idx + 2'd1;
                        partial  <= word_next[23:0];
                    end
                end

                if (wr_en) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                if (rd_en) begin
                    rd_ptr  <= rd_ptr + PTR_ONE;
                    rd_data <= mem[rd_ptr];
                end

                case ({wr_en, rd_en})
                    2'b10:   count <= count + CNT_ONE;
                    2'b01:   count <= count - CNT_ONE;
                    default: count <= count;
                endcase
            end
        end
    end

`ifdef CSI_READ32_FRAME_EOF_EN
    always_ff @(posedge bus_clk or posedge reset) begin
        if (reset) begin
            eof_pending <= 1'b0;
        end else if (!user_r_read_32_open) begin
            eof_pending <= 1'b0;
        end else if (commit && csi_last) begin
            eof_pending <= 1'b1;
        end
    end

    assign user_r_read_32_eof = eof_pending && (count == '0);
`else
    assign eof_pending        = 1'b0;
    assign user_r_read_32_eof = 1'b0;
`endif

endmodule
